// File: rtl/bbc_sd_pkg.sv
// Shared types and helpers for the SD-card SPI initiator.
//   spi_state_t   : byte-transfer FSM states
//   SPI_BYTE_BITS : bits per transfer
//   div_width()   : half-period counter width for a pair of divisors
package bbc_sd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } spi_state_t;

   localparam int SPI_BYTE_BITS = 8;

   // Wide enough to hold the larger divisor (the counter only ever loads DIV-1,
   // but the +1 keeps DIV=1 at a legal 1-bit width).
   function automatic int div_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/bbc_spi_halfdiv.sv
// Loadable down-counter that times one SCK half-period.
//   clk_sys, reset : system clock, async active-high reset
//   load           : (re)start a half-period; takes priority over counting
//   div_sel        : 1 = DIV_FAST, 0 = DIV_SLOW, used only on load
//   tick           : one-cycle pulse in the last cycle of the half-period
module bbc_spi_halfdiv
   import bbc_sd_pkg::*;
#(
   parameter int DIV_SLOW = 64,
   parameter int DIV_FAST = 2
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic load,
   input  logic div_sel,
   output logic tick
);

   localparam int CW = div_width(DIV_SLOW, DIV_FAST);
   localparam logic [CW-1:0] LOAD_SLOW = CW'(DIV_SLOW - 1);
   localparam logic [CW-1:0] LOAD_FAST = CW'(DIV_FAST - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          armed_q, armed_d;

   // armed keeps tick a single pulse: once the count hits zero without a
   // reload the counter goes quiet until the next load.
   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (load) begin
         cnt_d   = div_sel ? LOAD_FAST : LOAD_SLOW;
         armed_d = 1'b1;
      end else if (armed_q) begin
         if (cnt_q == '0) armed_d = 1'b0;
         else             cnt_d   = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   assign tick = armed_q & (cnt_q == '0);

endmodule

// File: rtl/bbc_sd_spi_master.sv
// Byte-wide SPI initiator (mode 0, MSB first) for the SD card bus.
//   clk_sys, reset      : system clock, async active-high reset
//   fast                : divisor select, captured when a byte is accepted
//   cs_assert           : request card select (ss low); applied only while idle
//   tx_valid/tx_ready   : byte handshake; tx_data is the byte to send
//   rx_valid/rx_data    : one-cycle pulse with the received byte (held after)
//   busy                : transfer in progress
//   sck/mosi/ss/miso    : SPI pins; miso is already synchronous to clk_sys
// All outputs are registered. Idle line: sck=0, mosi=1 (0xFF filler).
module bbc_sd_spi_master
   import bbc_sd_pkg::*;
#(
   parameter int DIV_SLOW = 64,
   parameter int DIV_FAST = 2
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       fast,
   input  logic       cs_assert,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       sck,
   output logic       mosi,
   output logic       ss,
   input  logic       miso
);

   if (DIV_SLOW < 1 || DIV_FAST < 1) begin : g_bad_div
      $error("bbc_sd_spi_master: DIV_SLOW and DIV_FAST must both be >= 1");
   end

   localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_BITS - 1);

   spi_state_t               state_q, state_d;
   logic [SPI_BYTE_BITS-1:0] shift_q, shift_d;
   logic [2:0]               bit_q, bit_d;
   logic                     fast_q, fast_d;
   logic                     sck_q, sck_d;
   logic                     mosi_q, mosi_d;
   logic                     ss_q, ss_d;
   logic                     tx_ready_q, tx_ready_d;
   logic                     busy_q, busy_d;
   logic                     rx_valid_q, rx_valid_d;
   logic [7:0]               rx_data_q, rx_data_d;

   logic load, div_sel, tick;

   // On the accept cycle the divisor comes straight from the port, since
   // fast_q is only being written at that same edge.
   assign div_sel = (state_q == IDLE) ? fast : fast_q;

   bbc_spi_halfdiv #(
      .DIV_SLOW (DIV_SLOW),
      .DIV_FAST (DIV_FAST)
   ) u_halfdiv (
      .clk_sys (clk_sys),
      .reset   (reset),
      .load    (load),
      .div_sel (div_sel),
      .tick    (tick)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_d      = bit_q;
      fast_d     = fast_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      ss_d       = ss_q;
      tx_ready_d = tx_ready_q;
      busy_d     = busy_q;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      load       = 1'b0;

      case (state_q)
         IDLE: begin
            sck_d  = 1'b0;
            mosi_d = 1'b1;
            // ss follows cs_assert only here, so a byte never sees ss move;
            // a same-cycle accept still gets ss one full half-period early.
            ss_d   = ~cs_assert;
            if (tx_valid) begin
               shift_d    = tx_data;
               fast_d     = fast;
               mosi_d     = tx_data[7];
               bit_d      = 3'd0;
               load       = 1'b1;
               tx_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = LOW;
            end
         end
         LOW: begin
            if (tick) begin
               sck_d   = 1'b1;
               // Sample on the rising edge: the outgoing MSB leaves the top,
               // the incoming bit enters at the bottom.
               shift_d = {shift_q[SPI_BYTE_BITS-2:0], miso};
               load    = 1'b1;
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (tick) begin
               sck_d = 1'b0;
               if (bit_q == LAST_BIT) begin
                  mosi_d     = 1'b1;
                  rx_valid_d = 1'b1;
                  rx_data_d  = shift_q;
                  state_d    = DONE;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  mosi_d  = shift_q[SPI_BYTE_BITS-1];
                  load    = 1'b1;
                  state_d = LOW;
               end
            end
         end
         DONE: begin
            tx_ready_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_q      <= '0;
         fast_q     <= 1'b0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b1;
         ss_q       <= 1'b1;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_q      <= bit_d;
         fast_q     <= fast_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         ss_q       <= ss_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

   assign tx_ready = tx_ready_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign busy     = busy_q;
   assign sck      = sck_q;
   assign mosi     = mosi_q;
   assign ss       = ss_q;

endmodule

// File: tb/tb_bbc_sd_spi_master.sv
// Directed bench for bbc_sd_spi_master with a scoreboard: every accepted byte
// pushes its expected rx byte and latency; every rx_valid pops and compares.
module tb_bbc_sd_spi_master;

   localparam int DIV_SLOW = 64;
   localparam int DIV_FAST = 2;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       fast;
   logic       cs_assert;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       busy;
   logic       sck;
   logic       mosi;
   logic       ss;
   logic       miso;
   logic       miso_hi;

   assign miso = miso_hi ? 1'b1 : mosi;

   always #5 clk_sys = ~clk_sys;

   bbc_sd_spi_master #(
      .DIV_SLOW (DIV_SLOW),
      .DIV_FAST (DIV_FAST)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .fast      (fast),
      .cs_assert (cs_assert),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .busy      (busy),
      .sck       (sck),
      .mosi      (mosi),
      .ss        (ss),
      .miso      (miso)
   );

   typedef struct {
      logic [7:0] data;
      int         lat;
      int         acc;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         rises = 0;
   int         rise_cyc = 0;
   int         high_len = 0;
   int         rx_cnt = 0;
   int         acc_cnt = 0;
   int         rx_cyc = 0;
   int         acc_cyc = 0;
   int         overlap = 0;
   logic       sck_prev = 1'b0;
   logic       sck_at_rx = 1'b0;
   logic       sck_at_acc = 1'b0;
   logic [7:0] mosi_bits = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor / scoreboard, sampling on the inactive edge.
   always @(negedge clk_sys) begin
      exp_t e;
      cyc++;
      if (sck && !sck_prev) begin
         rises++;
         rise_cyc  = cyc;
         mosi_bits = {mosi_bits[6:0], mosi};
      end
      if (!sck && sck_prev) high_len = cyc - rise_cyc;
      sck_prev = sck;
      if (rx_valid && tx_ready) overlap++;
      if (tx_valid && tx_ready && !reset) begin
         e.data = miso_hi ? 8'hFF : tx_data;
         e.lat  = 16 * (fast ? DIV_FAST : DIV_SLOW) + 1;
         e.acc  = cyc;
         exp_q.push_back(e);
         acc_cnt++;
         acc_cyc    = cyc;
         sck_at_acc = sck;
      end
      if (rx_valid) begin
         rx_cnt++;
         rx_cyc    = cyc;
         sck_at_rx = sck;
         if (exp_q.size() == 0) begin
            check("rx_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("rx_data", 32'(rx_data), 32'(e.data));
            check("rx_latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
   end

   task automatic tick1();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      tick1();
      tx_data  = d;
      tx_valid = 1'b1;
      tick1();
      tx_valid = 1'b0;
   endtask

   task automatic wait_rx(input int target, input int bound);
      int n;
      n = 0;
      while (rx_cnt < target && n < bound) begin
         tick1();
         n++;
      end
      check("rx_wait", 32'(rx_cnt >= target), 32'd1);
   endtask

   initial begin
      int n;
      int rx0;
      int acc0;
      logic ss_seen_high;

      reset     = 1'b1;
      fast      = 1'b1;
      cs_assert = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      miso_hi   = 1'b0;
      repeat (3) tick1();

      // Reset state
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd1);
      check("rst_ss", 32'(ss), 32'd1);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      reset = 1'b0;
      repeat (2) tick1();

      // 1: fast loopback, 0xA5
      rises = 0;
      send(8'hA5);
      wait_rx(1, 100);
      tick1();
      check("t1_rises", 32'(rises), 32'd8);
      check("t1_mosi_bits", 32'(mosi_bits), 32'hA5);

      // 2: slow, miso tied high, 0x3C
      fast    = 1'b0;
      miso_hi = 1'b1;
      rises   = 0;
      send(8'h3C);
      wait_rx(2, 1200);
      tick1();
      check("t2_rises", 32'(rises), 32'd8);
      check("t2_mosi_bits", 32'(mosi_bits), 32'h3C);
      check("t2_high_len", 32'(high_len), 32'(DIV_SLOW));
      miso_hi = 1'b0;

      // 3: cs_assert dropped mid-byte is deferred until the byte completes
      fast      = 1'b1;
      cs_assert = 1'b1;
      repeat (2) tick1();
      check("t3_ss_sel", 32'(ss), 32'd0);
      rises = 0;
      send(8'h96);
      n = 0;
      while (rises < 4 && n < 100) begin
         tick1();
         n++;
      end
      cs_assert    = 1'b0;
      ss_seen_high = 1'b0;
      n = 0;
      while (!rx_valid && n < 100) begin
         ss_seen_high |= ss;
         tick1();
         n++;
      end
      check("t3_reach_done", 32'(rx_valid), 32'd1);
      check("t3_ss_held", 32'(ss_seen_high | ss), 32'd0);
      repeat (2) tick1();
      check("t3_ss_release", 32'(ss), 32'd1);
      wait_rx(3, 10);

      // 4: async reset in the HIGH phase of bit 5
      cs_assert = 1'b1;
      repeat (2) tick1();
      rises = 0;
      rx0   = rx_cnt;
      send(8'h00);
      n = 0;
      while (rises < 6 && n < 100) begin
         tick1();
         n++;
      end
      check("t4_in_high", 32'(sck), 32'd1);
      reset = 1'b1;
      #1;
      check("t4_sck", 32'(sck), 32'd0);
      check("t4_ss", 32'(ss), 32'd1);
      check("t4_mosi", 32'(mosi), 32'd1);
      check("t4_tx_ready", 32'(tx_ready), 32'd1);
      exp_q.delete();
      tick1();
      reset = 1'b0;
      repeat (80) tick1();
      check("t4_no_rx", 32'(rx_cnt), 32'(rx0));

      // 5: tx_valid held across two bytes
      rises = 0;
      acc0  = acc_cnt;
      rx0   = rx_cnt;
      tick1();
      tx_data  = 8'h01;
      tx_valid = 1'b1;
      n = 0;
      while (acc_cnt < acc0 + 1 && n < 10) begin
         tick1();
         n++;
      end
      tx_data = 8'h80;
      n = 0;
      while (acc_cnt < acc0 + 2 && n < 100) begin
         tick1();
         n++;
      end
      tx_valid = 1'b0;
      check("t5_second_accept", 32'(acc_cnt), 32'(acc0 + 2));
      check("t5_b2b_gap", 32'(acc_cyc - rx_cyc), 32'd1);
      check("t5_sck_at_done", 32'(sck_at_rx), 32'd0);
      check("t5_sck_at_idle", 32'(sck_at_acc), 32'd0);
      wait_rx(rx0 + 2, 100);
      tick1();
      check("t5_rises", 32'(rises), 32'd16);

      // 6: fast changed mid-byte only affects the next byte
      fast = 1'b0;
      rx0  = rx_cnt;
      send(8'h5A);
      repeat (100) tick1();
      fast = 1'b1;
      wait_rx(rx0 + 1, 1200);
      send(8'hC3);
      wait_rx(rx0 + 2, 100);

      repeat (4) tick1();
      check("rx_tx_overlap", 32'(overlap), 32'd0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
